datapath_sequencer: RTL and testbench

//  Multi-cycle control FSM for the PC / instruction-ROM / register-file / ALU datapath.

---
 rtl/seq_pkg.sv | 44 ++++
 rtl/seq_funct_decode.sv | 35 +++
 rtl/datapath_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_datapath_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the datapath sequencer and its ALU-control decode.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_PAUSE  = 3'd5,
    ST_HALT   = 3'd6
  } seq_state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_func_e;

  localparam logic [5:0]  FN_ADD = 6'h20;
  localparam logic [5:0]  FN_SUB = 6'h22;
  localparam logic [5:0]  FN_AND = 6'h24;
  localparam logic [5:0]  FN_OR  = 6'h25;

  localparam logic [5:0]  OPC_RTYPE     = 6'h00;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

  // Register-file address fields of an R-type instruction word.
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } rf_addr_t;

  function automatic rf_addr_t ir_fields(input logic [31:0] ir);
    rf_addr_t f;
    f.rs = ir[25:21];
    f.rt = ir[20:16];
    f.rd = ir[15:11];
    return f;
  endfunction

endpackage

// File: rtl/seq_funct_decode.sv
// Combinational R-type decode: instruction word -> legality and 2-bit ALU function.
// Also used by the ALU-control path, so it knows nothing about the halt word.
module seq_funct_decode
  import seq_pkg::*;
(
  input  logic [31:0] i_ir,
  output logic        o_legal,
  output logic [1:0]  o_alu_func
);

  logic [5:0] w_opcode;
  logic [5:0] w_funct;
  alu_func_e  w_func;
  logic       w_funct_ok;

  assign w_opcode = i_ir[31:26];
  assign w_funct  = i_ir[5:0];

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (latch).
  always_comb begin
    w_func     = ALU_ADD;
    w_funct_ok = 1'b1;
    unique case (w_funct)
      FN_ADD:  w_func = ALU_ADD;
      FN_SUB:  w_func = ALU_SUB;
      FN_AND:  w_func = ALU_AND;
      FN_OR:   w_func = ALU_OR;
      default: w_funct_ok = 1'b0;
    endcase
  end

  assign o_legal    = (w_opcode == OPC_RTYPE) && w_funct_ok;
  assign o_alu_func = w_func;

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB controller for the PC / ROM / register-file / ALU datapath,
// with start, single-step, halt, illegal-instruction and fetch-timeout handling.
module datapath_sequencer
  import seq_pkg::*;
#(
  parameter int          RET_W         = 16,
  parameter logic [31:0] HALT_WORD     = HALT_WORD_DEF,
  parameter int          FETCH_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step_req,
  input  logic [31:0]      instr,
  input  logic             imem_ready,
  output logic             imem_re,
  output logic             pc_we,
  output logic             rf_en,
  output logic             rf_we,
  output logic [4:0]       rs_addr,
  output logic [4:0]       rt_addr,
  output logic [4:0]       rd_addr,
  output logic [1:0]       alu_func,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic             fetch_err,
  output logic [RET_W-1:0] retired_cnt
);

  localparam logic [7:0] WAIT_LAST = 8'(FETCH_TIMEOUT - 1);

  seq_state_e       r_state;
  seq_state_e       w_state_nxt;
  logic [31:0]      r_ir;
  logic [7:0]       r_wait_cnt;
  logic [RET_W-1:0] r_retired;
  logic             r_illegal;
  logic             r_fetch_err;

  logic             w_legal;
  logic [1:0]       w_alu_func;
  logic             w_is_halt;
  logic             w_load_ir;
  logic             w_set_illegal;
  logic             w_set_fetch_err;
  logic             w_retire;
  rf_addr_t         w_fields;

  seq_funct_decode u_funct_decode (
    .i_ir       (r_ir),
    .o_legal    (w_legal),
    .o_alu_func (w_alu_func)
  );

  assign w_is_halt = (r_ir == HALT_WORD);
  assign w_fields  = ir_fields(r_ir);

  // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_load_ir       = 1'b0;
    w_set_illegal   = 1'b0;
    w_set_fetch_err = 1'b0;
    w_retire        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ready) begin
          w_load_ir   = 1'b1;
          w_state_nxt = ST_DECODE;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_set_fetch_err = 1'b1;
          w_state_nxt     = ST_HALT;
        end
      end
      ST_DECODE: begin
        // The halt word is checked first: its opcode field would otherwise read as illegal.
        if (w_is_halt) begin
          w_state_nxt = ST_HALT;
        end else if (!w_legal) begin
          w_set_illegal = 1'b1;
          w_state_nxt   = step_mode ? ST_PAUSE : ST_FETCH;
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_state_nxt = ST_WB;
      end
      ST_WB: begin
        w_retire    = 1'b1;
        w_state_nxt = step_mode ? ST_PAUSE : ST_FETCH;
      end
      ST_PAUSE: begin
        if (step_req || !step_mode) w_state_nxt = ST_FETCH;
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // NOTE: every register here, IR included, is reset explicitly so the first post-reset outputs are all zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir        <= '0;
      r_wait_cnt  <= '0;
      r_retired   <= '0;
      r_illegal   <= 1'b0;
      r_fetch_err <= 1'b0;
    end else begin
      if (w_load_ir) r_ir <= instr;

      // Wait counter runs only while FETCH stalls; it is zero on every FETCH entry.
      if (r_state == ST_FETCH && !imem_ready) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end else begin
        r_wait_cnt <= '0;
      end

      if (w_retire && (r_retired != {RET_W{1'b1}})) begin
        r_retired <= r_retired + RET_W'(1);
      end

      if (w_set_illegal)   r_illegal   <= 1'b1;
      if (w_set_fetch_err) r_fetch_err <= 1'b1;
    end
  end

  // Moore outputs decoded from the state register and IR.
  always_comb begin
    imem_re  = 1'b0;
    pc_we    = 1'b0;
    rf_en    = 1'b0;
    rf_we    = 1'b0;
    alu_func = ALU_ADD;
    unique case (r_state)
      ST_FETCH:  imem_re = 1'b1;
      ST_DECODE: begin
        rf_en = 1'b1;
        pc_we = !w_is_halt && !w_legal;
      end
      ST_EXEC: begin
        rf_en    = 1'b1;
        alu_func = w_alu_func;
      end
      ST_WB: begin
        rf_en    = 1'b1;
        alu_func = w_alu_func;
        pc_we    = 1'b1;
        rf_we    = (w_fields.rd != 5'd0);
      end
      default: ;
    endcase
  end

  assign rs_addr     = w_fields.rs;
  assign rt_addr     = w_fields.rt;
  assign rd_addr     = w_fields.rd;
  assign busy        = (r_state != ST_IDLE) && (r_state != ST_HALT);
  assign halted      = (r_state == ST_HALT);
  assign illegal     = r_illegal;
  assign fetch_err   = r_fetch_err;
  assign retired_cnt = r_retired;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: hand-computed expectations checked with immediate assertions.
module tb_datapath_sequencer;

  localparam logic [31:0] I_ADD  = 32'h0022_1820; // add r3,r1,r2
  localparam logic [31:0] I_SUB  = 32'h0022_2022; // sub r4,r1,r2
  localparam logic [31:0] I_AND  = 32'h0022_2824; // and r5,r1,r2
  localparam logic [31:0] I_OR   = 32'h0022_3025; // or  r6,r1,r2
  localparam logic [31:0] I_ADD0 = 32'h0022_0020; // add r0,r1,r2
  localparam logic [31:0] I_BADF = 32'h0000_1826; // funct 0x26
  localparam logic [31:0] I_BADO = 32'h0822_1820; // opcode 2
  localparam logic [31:0] I_HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, start, step_mode, step_req, imem_ready;
  logic [31:0] instr;
  logic        imem_re, pc_we, rf_en, rf_we, busy, halted, illegal, fetch_err;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [1:0]  alu_func;
  logic [15:0] retired_cnt;

  int n_pass  = 0;
  int n_total = 0;
  int pc_cnt  = 0;
  int rf_cnt  = 0;

  always #5 clk = ~clk;

  datapath_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .step_mode   (step_mode),
    .step_req    (step_req),
    .instr       (instr),
    .imem_ready  (imem_ready),
    .imem_re     (imem_re),
    .pc_we       (pc_we),
    .rf_en       (rf_en),
    .rf_we       (rf_we),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rd_addr     (rd_addr),
    .alu_func    (alu_func),
    .busy        (busy),
    .halted      (halted),
    .illegal     (illegal),
    .fetch_err   (fetch_err),
    .retired_cnt (retired_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobes are tallied from the stable mid-cycle value, then one clock edge is taken.
  task automatic tick();
    if (pc_we === 1'b1) pc_cnt++;
    if (rf_we === 1'b1) rf_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    start    = 1'b0;
    step_req = 1'b0;
    tick();
    rst    = 1'b0;
    pc_cnt = 0;
    rf_cnt = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // From FETCH with a zero-wait ROM: runs one legal instruction through WB, back to FETCH/PAUSE.
  task automatic run_instr(input string tag, input logic [31:0] word, input logic [1:0] exp_alu,
                           input logic exp_rf_we);
    instr      = word;
    imem_ready = 1'b1;
    tick();
    tick();
    check({tag, "_exec_alu"}, 32'(alu_func), 32'(exp_alu));
    tick();
    check({tag, "_wb_pc_we"}, 32'(pc_we), 32'd1);
    check({tag, "_wb_rf_we"}, 32'(rf_we), 32'(exp_rf_we));
    check({tag, "_wb_alu"}, 32'(alu_func), 32'(exp_alu));
    tick();
  endtask

  initial begin
    step_mode  = 1'b0;
    imem_ready = 1'b1;
    instr      = '0;

    // 1. reset state, then ADD r3,r1,r2 cycle by cycle.
    rst = 1'b1; start = 1'b1; step_req = 1'b0;
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_vs_start_imem_re", 32'(imem_re), 32'd0);
    check("rst_retired", 32'(retired_cnt), 32'd0);
    check("rst_flags", {30'd0, illegal, fetch_err}, 32'd0);
    do_reset();
    do_start();
    check("t1_fetch_imem_re", 32'(imem_re), 32'd1);
    instr = I_ADD;
    tick();
    check("t1_dec_rf_en", 32'(rf_en), 32'd1);
    check("t1_dec_pc_we", 32'(pc_we), 32'd0);
    check("t1_dec_addrs", {17'd0, rs_addr, rt_addr, rd_addr}, {17'd0, 5'd1, 5'd2, 5'd3});
    tick();
    check("t1_exec_rf_we", 32'(rf_we), 32'd0);
    tick();
    check("t1_wb_pc_rf_we", {30'd0, pc_we, rf_we}, 32'd3);
    check("t1_wb_rd", 32'(rd_addr), 32'd3);
    check("t1_wb_alu", 32'(alu_func), 32'd0);
    tick();
    check("t1_retired", 32'(retired_cnt), 32'd1);

    // 2. SUB, AND, OR, HALT from a fresh reset.
    do_reset();
    do_start();
    run_instr("t2_sub", I_SUB, 2'b01, 1'b1);
    run_instr("t2_and", I_AND, 2'b10, 1'b1);
    run_instr("t2_or",  I_OR,  2'b11, 1'b1);
    instr = I_HALT;
    tick();
    check("t2_halt_dec_pc_we", 32'(pc_we), 32'd0);
    tick();
    check("t2_halted", 32'(halted), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_pc_cnt", 32'(pc_cnt), 32'd3);
    check("t2_retired", 32'(retired_cnt), 32'd3);
    do_start();
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    check("t2_halt_sticky", {30'd0, halted, imem_re}, 32'd2);

    // 3. undecodable funct: one pc_we in DECODE, nothing retired.
    do_reset();
    do_start();
    check("t3_illegal_clear", 32'(illegal), 32'd0);
    instr = I_BADF;
    tick();
    check("t3_dec_pc_we", 32'(pc_we), 32'd1);
    tick();
    check("t3_back_to_fetch", 32'(imem_re), 32'd1);
    check("t3_illegal", 32'(illegal), 32'd1);
    check("t3_retired", 32'(retired_cnt), 32'd0);
    check("t3_pc_rf_cnt", {pc_cnt[15:0], rf_cnt[15:0]}, {16'd1, 16'd0});

    // 4. write to r0 is suppressed but still retires.
    run_instr("t4_add_r0", I_ADD0, 2'b00, 1'b0);
    check("t4_retired", 32'(retired_cnt), 32'd1);
    check("t4_illegal_sticky", 32'(illegal), 32'd1);

    // Non-zero opcode is illegal too.
    do_reset();
    do_start();
    instr = I_BADO;
    tick();
    tick();
    check("t4_bad_opcode", {30'd0, illegal, imem_re}, 32'd3);

    // 5a. ROM never ready: 15 FETCH cycles, then HALT with fetch_err.
    do_reset();
    imem_ready = 1'b0;
    do_start();
    for (int i = 0; i < 14; i++) tick();
    check("t5_fetch15_still_fetch", {30'd0, imem_re, fetch_err}, 32'd2);
    tick();
    check("t5_timeout", {29'd0, halted, fetch_err, imem_re}, 32'd6);

    // 5b. three wait cycles: WB lands in cycle 7.
    do_reset();
    imem_ready = 1'b0;
    instr      = I_ADD;
    do_start();
    tick(); tick(); tick();
    imem_ready = 1'b1;
    tick();
    check("t5_wait_dec", 32'(rf_en), 32'd1);
    tick(); tick();
    check("t5_wait_wb_cycle7", {30'd0, pc_we, rf_we}, 32'd3);
    tick();
    check("t5_wait_err", {30'd0, fetch_err, halted}, 32'd0);
    check("t5_wait_retired", 32'(retired_cnt), 32'd1);

    // 6. single-step: PAUSE after WB, step_req releases it.
    do_reset();
    step_mode = 1'b1;
    do_start();
    run_instr("t6_add", I_ADD, 2'b00, 1'b1);
    check("t6_pause", {30'd0, busy, imem_re}, 32'd2);
    tick();
    check("t6_pause_hold", 32'(imem_re), 32'd0);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    check("t6_step_fetch", 32'(imem_re), 32'd1);
    run_instr("t6_sub", I_SUB, 2'b01, 1'b1);
    step_mode = 1'b0;
    tick();
    check("t6_mode_clear_fetch", 32'(imem_re), 32'd1);
    check("t6_retired", 32'(retired_cnt), 32'd2);

    // Reset mid-instruction (EXEC).
    instr = I_OR;
    tick();
    tick();
    check("t6_in_exec_alu", 32'(alu_func), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_outs", {22'd0, busy, halted, imem_re, pc_we, rf_en, rf_we, alu_func, illegal, fetch_err},
          32'd0);
    check("t6_rst_addrs", {17'd0, rs_addr, rt_addr, rd_addr}, 32'd0);
    check("t6_rst_retired", 32'(retired_cnt), 32'd0);
    tick();
    check("t6_idle_stays", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
